// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Package : mac_pkg
// Purpose : Shared constants and FSM state type for the 16-lane MAC
//           sequencer and its writeback helpers.
// Revision: 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int N        = 16;                    // MAC lanes per chunk
    localparam int WI       = 8;                     // operand width
    localparam int WA       = 2*WI + $clog2(N) + 2;  // MAC partial-sum width (22)
    localparam int ACCW     = 32;                    // row accumulator width
    localparam int AW       = 12;                    // SRAM address width
    localparam int CW       = 12;                    // chunk/row counter width
    localparam int MAC_LAT  = 5;                     // vld_i -> vld_o cycles
    localparam int SRAM_LAT = 1;                     // read enable -> data cycles

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        POST  = 3'd3,
        OUT   = 3'd4,
        FIN   = 3'd5
    } state_t;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_requant.sv
`default_nettype none
// ============================================================================
// Module  : mac_requant
// Purpose : Combinational requantizer: round-half-up arithmetic right shift,
//           optional ReLU, saturation to signed int8.
// Ports   : acc_i   in  ACCW  signed accumulator
//           shift_i in  5     right-shift amount 0..31
//           relu_i  in  1     clamp negative results to zero
//           q_o     out 8     signed int8 result
// Revision: 1.0 - initial release
// ============================================================================
module mac_requant
    import mac_pkg::*;
(
    input  logic [ACCW-1:0] acc_i,
    input  logic [4:0]      shift_i,
    input  logic            relu_i,
    output logic [7:0]      q_o
);

    // One guard bit so adding the rounding constant to a near-max value
    // cannot wrap before the shift.
    localparam logic signed [ACCW:0] Q_MAX = (ACCW+1)'(127);
    localparam logic signed [ACCW:0] Q_MIN = (ACCW+1)'(-128);

    logic signed [ACCW:0] ext_d;
    logic signed [ACCW:0] rnd_d;
    logic signed [ACCW:0] sum_d;
    logic signed [ACCW:0] shd_d;

    always_comb begin
        ext_d = $signed({acc_i[ACCW-1], acc_i});
        rnd_d = '0;
        if (shift_i != 5'd0) begin
            rnd_d = $signed((ACCW+1)'(1) << (shift_i - 5'd1));
        end
        sum_d = ext_d + rnd_d;
        shd_d = sum_d >>> shift_i;

        if (relu_i && shd_d[ACCW]) begin
            q_o = 8'd0;
        end else if (shd_d > Q_MAX) begin
            q_o = 8'h7F;
        end else if (shd_d < Q_MIN) begin
            q_o = 8'h80;
        end else begin
            q_o = shd_d[7:0];
        end
    end

endmodule : mac_requant
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mac_seq_ctrl
// Purpose : Matrix-vector sequencer for the 16-lane pipelined MAC. For each
//           output row it reads cfg_chunks weight/activation chunks, sums the
//           returned partial sums, requantizes to int8 and presents one
//           result per row on a valid/ready port.
// Ports   : clk, rst                      clock / sync active-high reset
//           start, cfg_*                  job launch and configuration
//           busy, done                    job status
//           w_rd_*, a_rd_*                buffer SRAM read ports
//           mac_vld_i / mac_vld_o, mac_acc MAC handshake and partial sum
//           out_valid/ready/data/acc      result port
// Revision: 1.0 - initial release
// ============================================================================
module mac_seq_ctrl
    import mac_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   cfg_chunks,
    input  logic [CW-1:0]   cfg_rows,
    input  logic [4:0]      cfg_shift,
    input  logic            cfg_relu,
    output logic            busy,
    output logic            done,
    output logic            w_rd_en,
    output logic [AW-1:0]   w_rd_addr,
    output logic            a_rd_en,
    output logic [AW-1:0]   a_rd_addr,
    output logic            mac_vld_i,
    input  logic            mac_vld_o,
    input  logic [WA-1:0]   mac_acc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic [ACCW-1:0] out_acc
);

    state_t          state_q, state_d;

    logic [CW-1:0]   chunks_q, rows_q;
    logic [4:0]      shift_q;
    logic            relu_q;
    logic [CW-1:0]   chunk_q, row_q, ret_q;
    logic [AW-1:0]   waddr_q;
    logic            mvld_q;
    logic [ACCW-1:0] acc_q;
    logic [7:0]      odata_q;
    logic [ACCW-1:0] oacc_q;

    logic            start_acc_d;
    logic            acc_en_d;
    logic [CW-1:0]   ret_nxt_d;
    logic            accept_d;
    logic            enter_issue_d;
    logic [ACCW-1:0] mac_ext_d;
    logic [7:0]      req_q_d;

    // ------------------------------------------------------------------
    // Shared control terms
    // ------------------------------------------------------------------
    always_comb begin
        start_acc_d = start && (state_q == IDLE);
        // Returns outside ISSUE/DRAIN (e.g. stragglers after a reset) are dropped.
        acc_en_d    = mac_vld_o && ((state_q == ISSUE) || (state_q == DRAIN));
        // The drain exit looks at the count including this cycle's return so
        // POST follows the final return without an extra idle cycle.
        ret_nxt_d   = ret_q + CW'(acc_en_d);
        accept_d    = (state_q == OUT) && out_ready;
        mac_ext_d   = {{(ACCW-WA){mac_acc[WA-1]}}, mac_acc};
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ((cfg_chunks == '0) || (cfg_rows == '0)) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (chunk_q == chunks_q - CW'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_nxt_d == chunks_q) begin
                    state_d = POST;
                end
            end
            POST:    state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    state_d = (row_q == rows_q - CW'(1)) ? FIN : ISSUE;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        enter_issue_d = (state_d == ISSUE) && (state_q != ISSUE);
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
        w_rd_en   = (state_q == ISSUE);
        a_rd_en   = (state_q == ISSUE);
        out_valid = (state_q == OUT);
    end

    assign w_rd_addr = waddr_q;
    assign a_rd_addr = AW'(chunk_q);
    assign mac_vld_i = mvld_q;
    assign out_data  = odata_q;
    assign out_acc   = oacc_q;

    mac_requant u_requant (
        .acc_i   (acc_q),
        .shift_i (shift_q),
        .relu_i  (relu_q),
        .q_o     (req_q_d)
    );

    // ------------------------------------------------------------------
    // Datapath: config, counters, address, accumulator, result regs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            chunks_q <= '0;
            rows_q   <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            chunk_q  <= '0;
            row_q    <= '0;
            ret_q    <= '0;
            waddr_q  <= '0;
            mvld_q   <= 1'b0;
            acc_q    <= '0;
            odata_q  <= '0;
            oacc_q   <= '0;
        end else begin
            // SRAM data arrives one cycle after the read, so the MAC valid
            // is the read enable delayed by one.
            mvld_q <= (state_q == ISSUE);

            if (state_q == ISSUE) begin
                chunk_q <= chunk_q + CW'(1);
                // Linear weight address runs on across rows: row*chunks+chunk.
                waddr_q <= waddr_q + AW'(1);
            end

            if (acc_en_d) begin
                acc_q <= acc_q + mac_ext_d;
                ret_q <= ret_nxt_d;
            end

            if (enter_issue_d) begin
                chunk_q <= '0;
                ret_q   <= '0;
                acc_q   <= '0;
            end

            if (start_acc_d) begin
                chunks_q <= cfg_chunks;
                rows_q   <= cfg_rows;
                shift_q  <= cfg_shift;
                relu_q   <= cfg_relu;
                waddr_q  <= '0;
                row_q    <= '0;
            end

            if (state_q == POST) begin
                odata_q <= req_q_d;
                oacc_q  <= acc_q;
            end

            if (accept_d) begin
                row_q <= row_q + CW'(1);
            end
        end
    end

endmodule : mac_seq_ctrl
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_seq_ctrl
// Purpose : Self-checking bench for mac_seq_ctrl with a behavioural MAC model
//           and an arithmetic reference for the per-row result.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;
    import mac_pkg::*;

    logic            clk = 1'b0;
    logic            rst, start, cfg_relu, out_ready;
    logic [CW-1:0]   cfg_chunks, cfg_rows;
    logic [4:0]      cfg_shift;
    logic            busy, done, w_rd_en, a_rd_en, mac_vld_i, mac_vld_o, out_valid;
    logic [AW-1:0]   w_rd_addr, a_rd_addr;
    logic [WA-1:0]   mac_acc;
    logic [7:0]      out_data;
    logic [ACCW-1:0] out_acc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_chunks(cfg_chunks), .cfg_rows(cfg_rows),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
        .mac_vld_i(mac_vld_i), .mac_vld_o(mac_vld_o), .mac_acc(mac_acc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_acc(out_acc)
    );

    // ------------------------------------------------------------------
    // MAC model: fixed 5-cycle pipe, not reset (in-flight data survives rst).
    // Each issued chunk gets a value (fixed or random); gen_sum totals them.
    // ------------------------------------------------------------------
    bit          mac_fixed = 1'b1;
    longint      mac_fval  = 0;
    longint      gen_sum   = 0;
    logic [4:0]  vpipe     = '0;
    logic [WA-1:0] dpipe [5];

    initial for (int i = 0; i < 5; i++) dpipe[i] = '0;

    always @(posedge clk) begin
        longint v;
        v = 0;
        if (mac_vld_i) begin
            v = mac_fixed ? mac_fval
                          : longint'($urandom_range(0, 2097150)) - 64'sd1048575;
            gen_sum <= gen_sum + v;
        end
        vpipe    <= {vpipe[3:0], mac_vld_i};
        dpipe[0] <= WA'(v);
        for (int i = 1; i < 5; i++) dpipe[i] <= dpipe[i-1];
    end

    assign mac_vld_o = vpipe[4];
    assign mac_acc   = dpipe[4];

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference requant: floor division by 2^sh after adding half an LSB.
    function automatic longint ref_q(input longint acc, input int sh, input bit relu);
        longint d, num, q;
        d   = longint'(1) << sh;
        num = acc + ((sh > 0) ? d / 2 : 0);
        q   = num / d;
        if (num < 0 && (num % d) != 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    // Runs one job end to end and checks addresses, results, handshake and done.
    task automatic run_job(input int ch, input int rw, input int sh, input int rl,
                           input bit fixed, input longint fval,
                           input int hold, input bit poke);
        longint base, exp_acc;
        int     exp_waddr, nreads, cyc;
        logic [7:0]      od;
        logic [ACCW-1:0] oa;

        mac_fixed  = fixed;
        mac_fval   = fval;
        base       = gen_sum;
        exp_waddr  = 0;
        cfg_chunks = CW'(ch);
        cfg_rows   = CW'(rw);
        cfg_shift  = 5'(sh);
        cfg_relu   = rl[0];
        start      = 1'b1;
        tick();
        start      = 1'b0;

        if (ch == 0 || rw == 0) begin
            nreads = 0;
            chk("empty_done", done, 1);
            chk("empty_busy", busy, 1);
            if (w_rd_en) nreads++;
            tick();
            if (w_rd_en) nreads++;
            chk("empty_done_end", done, 0);
            chk("empty_busy_end", busy, 0);
            chk("empty_reads", nreads, 0);
            return;
        end

        chk("busy_after_start", busy, 1);
        for (int r = 0; r < rw; r++) begin
            out_ready = (hold == 0);
            nreads    = 0;
            for (cyc = 0; cyc < ch + 20 && !out_valid; cyc++) begin
                if (w_rd_en) begin
                    chk("w_rd_addr", w_rd_addr, exp_waddr);
                    chk("a_rd_addr", a_rd_addr, exp_waddr - r * ch);
                    chk("a_rd_en", a_rd_en, 1);
                    exp_waddr++;
                    nreads++;
                end
                // A second start with different config while busy must not stick.
                if (poke && r == 0 && cyc == 1) begin
                    start = 1'b1; cfg_chunks = CW'(ch + 3); cfg_rows = CW'(rw + 4);
                end else begin
                    start = 1'b0; cfg_chunks = CW'(ch); cfg_rows = CW'(rw);
                end
                tick();
            end
            start = 1'b0;
            chk("row_valid", out_valid, 1);
            chk("row_reads", nreads, ch);
            exp_acc = gen_sum - base;
            chk("out_acc", $signed(out_acc), exp_acc);
            chk("out_data", $signed(out_data), ref_q(exp_acc, sh, rl[0]));
            od = out_data;
            oa = out_acc;
            for (int k = 0; k < hold; k++) begin
                tick();
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, od);
                chk("hold_acc", out_acc, oa);
                chk("hold_no_read", w_rd_en, 0);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            base = gen_sum;
        end
        chk("done_pulse", done, 1);
        chk("busy_in_fin", busy, 1);
        tick();
        chk("done_end", done, 0);
        chk("busy_end", busy, 0);
    endtask

    // ------------------------------------------------------------------
    // Directed and randomized sequence
    // ------------------------------------------------------------------
    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        cfg_chunks = '0; cfg_rows = '0; cfg_shift = '0; cfg_relu = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wen", w_rd_en, 0);
        chk("rst_aen", a_rd_en, 0);
        chk("rst_mvld", mac_vld_i, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_waddr", w_rd_addr, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_oacc", out_acc, 0);
        rst = 1'b0;
        tick();

        run_job(1, 1, 0, 0, 1, 100, 0, 0);
        run_job(4, 3, 4, 0, 1, 1000, 0, 0);
        run_job(1, 1, 3, 0, 1, -40, 0, 0);
        run_job(1, 1, 3, 1, 1, -40, 0, 0);
        run_job(1, 1, 0, 0, 1, -1000, 0, 0);
        run_job(2, 2, 14, 0, 0, 0, 10, 0);
        run_job(3, 0, 0, 0, 1, 5, 0, 0);
        run_job(0, 2, 0, 0, 1, 5, 0, 0);
        run_job(3, 2, 12, 0, 0, 0, 0, 1);
        for (int j = 0; j < 5; j++) begin
            run_job($urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(12, 20),
                    $urandom_range(0, 1), 0, 0, $urandom_range(0, 3), 0);
        end
        run_job(2, 1, $urandom_range(0, 31), 0, 0, 0, 0, 0);

        // Reset in DRAIN: start a row, wait for the issue burst to finish.
        mac_fixed = 1'b0;
        cfg_chunks = CW'(3); cfg_rows = CW'(1); cfg_shift = 5'd0; cfg_relu = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (cyc = 0; cyc < 10 && w_rd_en; cyc++) tick();
        chk("drain_reached", busy && !w_rd_en && !out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_wen", w_rd_en, 0);
        chk("abort_oval", out_valid, 0);
        chk("abort_waddr", w_rd_addr, 0);
        chk("abort_oacc", out_acc, 0);
        chk("abort_odata", out_data, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("late_ret_idle", busy || out_valid || done, 0);
        end
        run_job(2, 2, 10, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mac_seq_ctrl
`default_nettype wire
